// File: rtl/packet_deframer_pkg.sv
// rtl/packet_deframer_pkg.sv - frame constants shared by the deframer and the packeter
package packet_deframer_pkg;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
  localparam int SAMPLE_W     = 12;
  localparam int HDR_TYPE_MSB = 7;
  localparam int HDR_TYPE_LSB = 6;
  localparam int HDR_LEN_MSB  = 5;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    TYPE_SAMPLES = 2'd0,
    TYPE_PPS     = 2'd1,
    TYPE_RESP    = 2'd2,
    TYPE_INVALID = 2'd3
  } frame_type_t;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  // Sample payloads must be whole byte triplets; anything else leaves a partial sample.
  function automatic logic samples_len_bad(input logic [5:0] len_m1);
    logic [6:0] len;
    len = {1'b0, len_m1} + 7'd1;
    return (len % 7'd3) != 7'd0;
  endfunction

endpackage

// File: rtl/packet_deframer_if.sv
// rtl/packet_deframer_if.sv - byte-in / 12-bit-sample-out ready/valid bundle
interface packet_deframer_if;
  import packet_deframer_pkg::*;

  logic                b_valid;
  logic [7:0]          b_data;
  logic                b_ready;
  logic                s_valid;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_ready;

  modport master (output b_valid, b_data, s_ready, input b_ready, s_valid, s_data);
  modport slave  (input b_valid, b_data, s_ready, output b_ready, s_valid, s_data);
endinterface

// File: rtl/packet_deframer_unpack.sv
// rtl/packet_deframer_unpack.sv - unpack8to12: byte triplets to two 12-bit samples
// Single output register; i_clear restarts the triplet and drops any held sample.
module unpack8to12
  import packet_deframer_pkg::*;
(
  input logic              clock,
  input logic              i_clear,
  packet_deframer_if.slave u
);
  logic [1:0]          r_idx;
  logic [7:0]          r_hold;
  logic                r_valid;
  logic [SAMPLE_W-1:0] r_data;
  logic                w_take;

  assign u.b_ready = !r_valid || u.s_ready;
  assign w_take    = u.b_valid && u.b_ready;
  assign u.s_valid = r_valid;
  assign u.s_data  = r_data;

  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_idx   <= 2'd0;
      r_hold  <= 8'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (r_valid && u.s_ready) r_valid <= 1'b0;
      if (w_take) begin
        case (r_idx)
          2'd0: begin
            r_hold <= u.b_data;
            r_idx  <= 2'd1;
          end
          2'd1: begin
            // Keep b1 so its low nibble can head sample B.
            r_data  <= {r_hold, u.b_data[7:4]};
            r_valid <= 1'b1;
            r_hold  <= u.b_data;
            r_idx   <= 2'd2;
          end
          default: begin
            r_data  <= {r_hold[3:0], u.b_data};
            r_valid <= 1'b1;
            r_idx   <= 2'd0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/packet_deframer.sv
// rtl/packet_deframer.sv - SYNC/header/payload/checksum frame parser with sample and aux outputs
// Define DEFRAMER_CHECKSUM_EN to verify the XOR checksum; otherwise it is consumed and ignored.
module packet_deframer
  import packet_deframer_pkg::*;
#(
  parameter logic [7:0] SYNC  = DEFAULT_SYNC,
  parameter int         CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  input  logic [7:0]       io_in_bits,
  output logic             io_in_ready,
  output logic             io_smp_valid,
  output logic [11:0]      io_smp_bits,
  input  logic             io_smp_ready,
  output logic             io_aux_valid,
  output logic [1:0]       io_aux_type,
  output logic [7:0]       io_aux_bits,
  input  logic             io_aux_ready,
  output logic             io_frame_done,
  output logic             io_frame_err,
  output logic [CNT_W-1:0] io_err_count,
  output logic [CNT_W-1:0] io_drop_count
);
  state_t           r_state, w_next;
  frame_type_t      r_type;
  logic [5:0]       r_left;
  logic             r_len_bad;
  logic             r_aux_valid;
  logic [1:0]       r_aux_type;
  logic [7:0]       r_aux_bits;
  logic             r_done, r_err;
  logic [CNT_W-1:0] r_err_cnt, r_drop_cnt;
  logic             w_out_free, w_accept, w_csum_bad, w_frame_end, w_frame_bad, w_hunt_drop;
  frame_type_t      w_hdr_type;

  packet_deframer_if u_unp_if ();

  assign w_hdr_type = frame_type_t'(io_in_bits[HDR_TYPE_MSB:HDR_TYPE_LSB]);
  assign w_accept   = io_in_valid && io_in_ready;

  assign u_unp_if.b_valid = io_in_valid && (r_state == ST_PAY) && (r_type == TYPE_SAMPLES);
  assign u_unp_if.b_data  = io_in_bits;
  assign u_unp_if.s_ready = io_smp_ready;
  assign io_smp_valid     = u_unp_if.s_valid;
  assign io_smp_bits      = u_unp_if.s_data;

  // Nothing can be pending while in HDR, so the header cycle restarts the triplet.
  unpack8to12 u_unpack (
    .clock   (clock),
    .i_clear (reset || (r_state == ST_HDR)),
    .u       (u_unp_if)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_HUNT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_HUNT: if (io_in_bits == SYNC) w_next = ST_HDR;
        ST_HDR:  w_next = (w_hdr_type == TYPE_INVALID) ? ST_HUNT : ST_PAY;
        ST_PAY:  if (r_left == 6'd0) w_next = ST_CSUM;
        default: w_next = ST_HUNT;
      endcase
    end
  end

  // CSUM also waits for the output register so frame_done never precedes the last word.
  always_comb begin
    w_out_free  = (r_type == TYPE_SAMPLES) ? u_unp_if.b_ready : (!r_aux_valid || io_aux_ready);
    io_in_ready = 1'b1;
    if ((r_state == ST_PAY) || (r_state == ST_CSUM)) io_in_ready = w_out_free;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_type    <= TYPE_SAMPLES;
      r_left    <= 6'd0;
      r_len_bad <= 1'b0;
    end else if (w_accept && (r_state == ST_HDR)) begin
      r_type    <= w_hdr_type;
      r_left    <= io_in_bits[HDR_LEN_MSB:HDR_LEN_LSB];
      r_len_bad <= (w_hdr_type == TYPE_SAMPLES) &&
                   samples_len_bad(io_in_bits[HDR_LEN_MSB:HDR_LEN_LSB]);
    end else if (w_accept && (r_state == ST_PAY)) begin
      r_left <= r_left - 6'd1;
    end
  end

`ifdef DEFRAMER_CHECKSUM_EN
  logic [7:0] r_csum;
  always_ff @(posedge clock) begin
    if (reset)                                r_csum <= 8'd0;
    else if (w_accept && (r_state == ST_HDR)) r_csum <= io_in_bits;
    else if (w_accept && (r_state == ST_PAY)) r_csum <= r_csum ^ io_in_bits;
  end
  assign w_csum_bad = (io_in_bits != r_csum);
`else
  assign w_csum_bad = 1'b0;
`endif

  assign w_hunt_drop = w_accept && (r_state == ST_HUNT) && (io_in_bits != SYNC);
  assign w_frame_end = w_accept && (((r_state == ST_HDR) && (w_hdr_type == TYPE_INVALID)) ||
                                    (r_state == ST_CSUM));
  assign w_frame_bad = (r_state == ST_HDR) || r_len_bad || w_csum_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_done <= w_frame_end;
      r_err  <= w_frame_end && w_frame_bad;
      if (w_frame_end && w_frame_bad && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (w_hunt_drop && (r_drop_cnt != '1))               r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_aux_valid <= 1'b0;
      r_aux_type  <= 2'd0;
      r_aux_bits  <= 8'd0;
    end else begin
      if (r_aux_valid && io_aux_ready) r_aux_valid <= 1'b0;
      if (w_accept && (r_state == ST_PAY) && (r_type != TYPE_SAMPLES)) begin
        r_aux_valid <= 1'b1;
        r_aux_type  <= r_type;
        r_aux_bits  <= io_in_bits;
      end
    end
  end

  assign io_aux_valid  = r_aux_valid;
  assign io_aux_type   = r_aux_type;
  assign io_aux_bits   = r_aux_bits;
  assign io_frame_done = r_done;
  assign io_frame_err  = r_err;
  assign io_err_count  = r_err_cnt;
  assign io_drop_count = r_drop_cnt;
endmodule
